// File: rtl/cordic_pkg.sv
// Shared constants and types for the polar-to-rectangular CORDIC family.
// Angles use binary-angle units: 2^32 counts per full turn before truncation to PH_BITS.
package cordic_pkg;

    localparam logic [31:0] CORDIC_KINV = 32'd1304065748;

    localparam logic [31:0] ATAN_TABLE [0:31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    typedef enum logic [1:0] {IDLE, CALC, DONE} cordic_state_t;

    function automatic logic [31:0] atan_entry(input logic [4:0] i, input int ph_bits);
        return ATAN_TABLE[i] >> (32 - ph_bits);
    endfunction

endpackage

// File: rtl/cordic_p2r_prescale.sv
// Combinational front end: CORDIC gain compensation and quadrant fold so the
// residual angle handed to the rotation stages stays inside +/-90 degrees.
module cordic_p2r_prescale
    import cordic_pkg::*;
#(
    parameter int XY_BITS = 32,
    parameter int PH_BITS = 32,
    parameter int GUARD   = 2
) (
    input  logic [XY_BITS-1:0]     mag,
    input  logic [PH_BITS-1:0]     phase,
    output logic [XY_BITS+GUARD:0] x0,
    output logic [PH_BITS-1:0]     z0
);
    logic [XY_BITS+31:0]    prod;
    logic [XY_BITS+GUARD:0] x_mag;
    logic                   fold;

    always_comb begin
        // Negative magnitudes are clamped to zero before scaling.
        prod  = (XY_BITS+32)'(mag[XY_BITS-1] ? '0 : mag) * (XY_BITS+32)'(CORDIC_KINV);
        x_mag = {1'b0, XY_BITS'(prod >> 31), {GUARD{1'b0}}};
        fold  = phase[PH_BITS-1] ^ phase[PH_BITS-2];
        x0    = fold ? -x_mag : x_mag;
        // Adding half a turn only flips the top phase bit.
        z0    = {phase[PH_BITS-1] ^ fold, phase[PH_BITS-2:0]};
    end

endmodule

// File: rtl/cordic_p2r_iter.sv
// Iterative polar-to-rectangular CORDIC: one micro-rotation per clock,
// valid/ready on both sides, result held in DONE until taken.
//
// state | meaning
// IDLE  | waiting for a sample, iready high
// CALC  | running micro-rotations, counter 0..ITERATIONS-1
// DONE  | result valid and held until oready
module cordic_p2r_iter
    import cordic_pkg::*;
#(
    parameter int XY_BITS    = 32,
    parameter int PH_BITS    = 32,
    parameter int ITERATIONS = 24,
    parameter int GUARD      = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ivalid,
    output logic               iready,
    input  logic [XY_BITS-1:0] mag_i,
    input  logic [PH_BITS-1:0] phase_i,
    output logic               ovalid,
    input  logic               oready,
    output logic [XY_BITS-1:0] x_o,
    output logic [XY_BITS-1:0] y_o,
    output logic               busy
);
    localparam int W = XY_BITS + GUARD + 1;

    cordic_state_t       state, state_nxt;
    logic signed [W-1:0] x_r, y_r, x_n, y_n, x0;
    logic [PH_BITS-1:0]  z_r, z_n, z0, atan_i;
    logic [XY_BITS:0]    x_rnd, y_rnd;
    logic [4:0]          cnt;
    logic                last;

    function automatic logic [XY_BITS-1:0] sat(input logic [XY_BITS:0] r);
        if (r[XY_BITS] != r[XY_BITS-1])
            return r[XY_BITS] ? {1'b1, {(XY_BITS-1){1'b0}}} : {1'b0, {(XY_BITS-1){1'b1}}};
        return r[XY_BITS-1:0];
    endfunction

    cordic_p2r_prescale #(
        .XY_BITS (XY_BITS),
        .PH_BITS (PH_BITS),
        .GUARD   (GUARD)
    ) u_prescale (
        .mag   (mag_i),
        .phase (phase_i),
        .x0    (x0),
        .z0    (z0)
    );

    assign last = (cnt == 5'(ITERATIONS - 1));

    always_comb begin
        atan_i = PH_BITS'(atan_entry(cnt, PH_BITS));
        if (!z_r[PH_BITS-1]) begin
            x_n = x_r - (y_r >>> cnt);
            y_n = y_r + (x_r >>> cnt);
            z_n = z_r - atan_i;
        end else begin
            x_n = x_r + (y_r >>> cnt);
            y_n = y_r - (x_r >>> cnt);
            z_n = z_r + atan_i;
        end
        // Round half up: add the bit just below the kept LSB.
        x_rnd = x_n[W-1:GUARD] + (XY_BITS+1)'(x_n[GUARD-1]);
        y_rnd = y_n[W-1:GUARD] + (XY_BITS+1)'(y_n[GUARD-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        iready    = 1'b0;
        ovalid    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                iready = 1'b1;
                busy   = 1'b0;
                if (ivalid) state_nxt = CALC;
            end
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                ovalid = 1'b1;
                if (oready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_r <= '0;
            y_r <= '0;
            z_r <= '0;
            cnt <= '0;
            x_o <= '0;
            y_o <= '0;
        end else begin
            case (state)
                IDLE: if (ivalid) begin
                    x_r <= x0;
                    y_r <= '0;
                    z_r <= z0;
                    cnt <= '0;
                end
                CALC: begin
                    x_r <= x_n;
                    y_r <= y_n;
                    z_r <= z_n;
                    cnt <= last ? 5'd0 : cnt + 5'd1;
                    if (last) begin
                        x_o <= sat(x_rnd);
                        y_o <= sat(y_rnd);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
